control_calculadora_bcd: RTL and testbench
==========================================

// Module: control_calculadora_bcd
// PURPOSE
//  Sequencer for the 4-digit BCD ALU (suma/resta/mult/modulo). It assembles operands A and B from
//  debounced keypad codes, latches the operator, and drives the ALU operands and op select.
//  It waits the ALU latency, captures the result and error flags, and presents the display word.
//  It sits between the keypad decoder and the ALU / 7-segment display driver.
// PARAMETERS
//  LAT_ALU   2   cycles from stable alu_a/alu_b/alu_op to valid alu_res (1..15)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  tecla_valida in   1   1-cycle strobe, tecla is valid
//  tecla        in   4   0-9 digit, 10 '+', 11 '-', 12 '*', 13 '%', 14 '=', 15 clear
//  alu_res      in   16  ALU BCD result
//  alu_neg      in   1   subtract result negative
//  alu_err      in   1   OR of suma Cout / mult overflow / DivideByZero, for the selected op
//  alu_a        out  16  operand A (BCD)
//  alu_b        out  16  operand B (BCD)
//  alu_op       out  2   00 suma, 01 resta, 10 mult, 11 modulo
//  display      out  16  BCD word to display
//  display_neg  out  1   minus sign lamp
//  error        out  1   error lamp
//  ocupado      out  1   high while in CALCULO
// BEHAVIOUR
//  Reset: all outputs 0, state INGRESO_A, internal A/B/result/op/counter 0.
//  States: INGRESO_A, INGRESO_B, CALCULO, RESULTADO, ERROR.
//  Clear (15) in any state: next cycle INGRESO_A, A=B=0, op=00, flags 0. Clear has priority.
//  Digit entry: reg <= {reg[11:0], d}. Only 4 digits are held.
//   - A 5th digit is ignored while reg[15:12]!=0.
//   - Leading zeros are not counted.
//  INGRESO_A:
//   - digit -> shift into A.
//   - op key -> latch op, B=0, go INGRESO_B.
//   - '=' ignored.
//  INGRESO_B:
//   - digit -> shift into B.
//   - op key -> replace op.
//   - '=' -> go CALCULO, load counter with LAT_ALU.
//  CALCULO:
//   - alu_a/alu_b/alu_op stay constant.
//   - The counter decrements each cycle. When it reaches 0, capture alu_res/alu_neg.
//   - Exit: alu_err ? ERROR : RESULTADO.
//   - Non-clear keys are ignored.
//   - Total latency from '=' strobe to new display: LAT_ALU+1 cycles.
//  RESULTADO:
//   - digit -> A = digit, B = 0, go INGRESO_A.
//   - op key with captured neg=0 -> A = result, latch op, B=0, go INGRESO_B (chaining).
//   - op key with neg=1 -> ignored.
//  ERROR:
//   - Only clear exits. display = 16'hFFFF, error = 1.
//  display:
//   - INGRESO_A: A. INGRESO_B: B. CALCULO: previous display held. RESULTADO: captured result.
//  display_neg = 1 only in RESULTADO with captured neg.
//  alu_a/alu_b are the registered A/B. alu_op is the registered op. All outputs are registered.
//  Reset asserted mid-CALCULO aborts the calculation with no capture.
// CONFIGURATION
//  CALC_ACUM_EN defined:
//   - '=' in RESULTADO (neg=0) sets A=result, keeps op and B, goes CALCULO (repeat last op).
//   - Example: 2+3== gives 0005, then 0008.
//  CALC_ACUM_EN undefined: '=' in RESULTADO is ignored.
// STRUCTURE
//  Package calc_bcd_pkg:
//   - key code localparams (TECLA_SUMA..TECLA_CLR)
//   - alu_op encodings
//   - state encoding
//   - ERROR_DISPLAY = 16'hFFFF
//  Sub-module registro_bcd_entrada: 4-digit shift-in register, instantiated twice (A, B).
//   - inputs: load_digit, clear, load_val
//   - output: 16-bit BCD
// TESTING
//  1. Keys 1,2,+,3,4,= with LAT_ALU=2:
//     - display 0012, then 0034.
//     - 3 cycles after '=': display 0034 -> 0046, ocupado high exactly 2 cycles.
//  2. Keys 5,-,8,=, alu_neg=1, alu_res=0003:
//     - display 0003, display_neg=1.
//     - A following '+' is ignored.
//  3. Keys 9,9,9,9,9:
//     - A holds 9999, 5th digit dropped.
//     - Then '*',2,= with alu_err=1: ERROR, display FFFF. Only clear restores 0000.
//  4. Keys 7,%,0,= with alu_err=1 (DivideByZero):
//     - ERROR, error=1.
//     - Digit keys ignored, clear -> INGRESO_A.
//  5. Chaining and reset:
//     - 2,+,3,= then '*',4,= gives 0020.
//     - rst_n low mid-CALCULO: all outputs 0 immediately, state INGRESO_A.
//  6. CALC_ACUM_EN: 2,+,3,=,= gives 0008. Undefined: second '=' leaves 0005.

Source files
------------

// File: rtl/calc_bcd_pkg.sv
// Shared definitions for the BCD calculator sequencer.
// Key codes, ALU op encodings, FSM states, display constants.
package calc_bcd_pkg;

  localparam logic [3:0] TECLA_SUMA  = 4'd10;
  localparam logic [3:0] TECLA_RESTA = 4'd11;
  localparam logic [3:0] TECLA_MULT  = 4'd12;
  localparam logic [3:0] TECLA_MOD   = 4'd13;
  localparam logic [3:0] TECLA_IGUAL = 4'd14;
  localparam logic [3:0] TECLA_CLR   = 4'd15;

  localparam logic [1:0] OP_SUMA   = 2'b00;
  localparam logic [1:0] OP_RESTA  = 2'b01;
  localparam logic [1:0] OP_MULT   = 2'b10;
  localparam logic [1:0] OP_MODULO = 2'b11;

  typedef enum logic [2:0] {
    INGRESO_A,
    INGRESO_B,
    CALCULO,
    RESULTADO,
    ERROR
  } estado_t;

  localparam logic [15:0] ERROR_DISPLAY = 16'hFFFF;

  // Keys 10..13 map onto ops 00..11 by flipping bit 1.
  function automatic logic [1:0] tecla_a_op(input logic [1:0] t);
    return t ^ 2'b10;
  endfunction

endpackage

// File: rtl/registro_bcd_entrada.sv
// 4-digit BCD shift-in register for one calculator operand.
// Priority: clear, then parallel load, then digit shift.
module registro_bcd_entrada
  import calc_bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_digit,
  input  logic [3:0]  digit,
  input  logic        clear,
  input  logic        load_val,
  input  logic [15:0] val,
  output logic [15:0] q,
  output logic [15:0] q_nxt
);

  // Next value; a full register (top digit non-zero) drops new digits.
  always_comb begin
    q_nxt = q;
    if (clear) begin
      q_nxt = '0;
    end else if (load_val) begin
      q_nxt = val;
    end else if (load_digit && (q[15:12] == 4'd0)) begin
      q_nxt = {q[11:0], digit};
    end
  end

  // Operand storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_nxt;
  end

endmodule

// File: rtl/control_calculadora_bcd.sv
// Keypad-to-ALU sequencer for the 4-digit BCD calculator.
// Optional macro CALC_ACUM_EN: '=' on a result repeats the last op.
module control_calculadora_bcd
  import calc_bcd_pkg::*;
#(
  parameter int LAT_ALU = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla,
  input  logic [15:0] alu_res,
  input  logic        alu_neg,
  input  logic        alu_err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  output logic [15:0] display,
  output logic        display_neg,
  output logic        error,
  output logic        ocupado
);

  localparam logic [3:0] LAT = 4'(LAT_ALU);

  estado_t     est, est_n;
  logic [3:0]  cnt, cnt_n;
  logic [1:0]  op_q, op_n;
  logic [15:0] res_q, res_n;
  logic        neg_q, neg_n;

  logic        a_clr, a_dig, a_ld, b_clr, b_dig;
  logic [15:0] a_val, a_q, a_nxt, b_q, b_nxt;
  logic [15:0] disp_n;

  logic k_dig, k_op, k_igual, k_clr;

  assign k_dig   = tecla_valida && (tecla <= 4'd9);
  assign k_op    = tecla_valida && (tecla >= TECLA_SUMA)
                && (tecla <= TECLA_MOD);
  assign k_igual = tecla_valida && (tecla == TECLA_IGUAL);
  assign k_clr   = tecla_valida && (tecla == TECLA_CLR);

  registro_bcd_entrada u_reg_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_digit (a_dig),
    .digit      (tecla),
    .clear      (a_clr),
    .load_val   (a_ld),
    .val        (a_val),
    .q          (a_q),
    .q_nxt      (a_nxt)
  );

  registro_bcd_entrada u_reg_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_digit (b_dig),
    .digit      (tecla),
    .clear      (b_clr),
    .load_val   (1'b0),
    .val        (16'h0000),
    .q          (b_q),
    .q_nxt      (b_nxt)
  );

  // Next state, operand control and result capture; clear wins.
  always_comb begin
    est_n = est;
    cnt_n = cnt;
    op_n  = op_q;
    res_n = res_q;
    neg_n = neg_q;
    a_clr = 1'b0;
    a_dig = 1'b0;
    a_ld  = 1'b0;
    a_val = res_q;
    b_clr = 1'b0;
    b_dig = 1'b0;
    if (k_clr) begin
      est_n = INGRESO_A;
      cnt_n = '0;
      op_n  = OP_SUMA;
      res_n = '0;
      neg_n = 1'b0;
      a_clr = 1'b1;
      b_clr = 1'b1;
    end else begin
      unique case (est)
        INGRESO_A: begin
          if (k_dig) begin
            a_dig = 1'b1;
          end else if (k_op) begin
            op_n  = tecla_a_op(tecla[1:0]);
            b_clr = 1'b1;
            est_n = INGRESO_B;
          end
        end
        INGRESO_B: begin
          if (k_dig) begin
            b_dig = 1'b1;
          end else if (k_op) begin
            op_n = tecla_a_op(tecla[1:0]);
          end else if (k_igual) begin
            cnt_n = LAT;
            est_n = CALCULO;
          end
        end
        CALCULO: begin
          cnt_n = cnt - 4'd1;
          if (cnt <= 4'd1) begin
            cnt_n = '0;
            res_n = alu_res;
            neg_n = alu_neg;
            est_n = alu_err ? ERROR : RESULTADO;
          end
        end
        RESULTADO: begin
          if (k_dig) begin
            a_ld  = 1'b1;
            a_val = {12'h000, tecla};
            b_clr = 1'b1;
            est_n = INGRESO_A;
          end else if (k_op && !neg_q) begin
            a_ld  = 1'b1;
            op_n  = tecla_a_op(tecla[1:0]);
            b_clr = 1'b1;
            est_n = INGRESO_B;
          end
`ifdef CALC_ACUM_EN
          else if (k_igual && !neg_q) begin
            a_ld  = 1'b1;
            cnt_n = LAT;
            est_n = CALCULO;
          end
`endif
        end
        ERROR: begin
        end
        default: est_n = INGRESO_A;
      endcase
    end
  end

  // Display word follows the state being entered.
  always_comb begin
    disp_n = display;
    unique case (est_n)
      INGRESO_A: disp_n = a_nxt;
      INGRESO_B: disp_n = b_nxt;
      CALCULO:   disp_n = display;
      RESULTADO: disp_n = res_n;
      ERROR:     disp_n = ERROR_DISPLAY;
      default:   disp_n = display;
    endcase
  end

  // State, latency counter, op and captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est   <= INGRESO_A;
      cnt   <= '0;
      op_q  <= OP_SUMA;
      res_q <= '0;
      neg_q <= 1'b0;
    end else begin
      est   <= est_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      res_q <= res_n;
      neg_q <= neg_n;
    end
  end

  // Registered lamps and display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display     <= '0;
      display_neg <= 1'b0;
      error       <= 1'b0;
      ocupado     <= 1'b0;
    end else begin
      display     <= disp_n;
      display_neg <= (est_n == RESULTADO) && neg_n;
      error       <= (est_n == ERROR);
      ocupado     <= (est_n == CALCULO);
    end
  end

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

endmodule

// File: tb/tb_control_calculadora_bcd.sv
// Directed bench for control_calculadora_bcd.
// Honours CALC_ACUM_EN when the RTL is built with it.
module tb_control_calculadora_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tecla_valida = 1'b0;
  logic [3:0]  tecla = 4'd0;
  logic [15:0] alu_res = 16'h0000;
  logic        alu_neg = 1'b0;
  logic        alu_err = 1'b0;
  logic [15:0] alu_a, alu_b, display;
  logic [1:0]  alu_op;
  logic        display_neg, error, ocupado;

  int n_ok  = 0;
  int n_tot = 0;

  control_calculadora_bcd #(.LAT_ALU(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tecla_valida (tecla_valida),
    .tecla        (tecla),
    .alu_res      (alu_res),
    .alu_neg      (alu_neg),
    .alu_err      (alu_err),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .display      (display),
    .display_neg  (display_neg),
    .error        (error),
    .ocupado      (ocupado)
  );

  always #5 clk = ~clk;

  task automatic chequear(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] esp);
    n_tot++;
    if (obs === esp) n_ok++;
    else $display("FAIL %s: got %h expected %h", tag, obs, esp);
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulsar(input logic [3:0] k);
    tecla_valida = 1'b1;
    tecla        = k;
    @(negedge clk);
    tecla_valida = 1'b0;
    tecla        = 4'd0;
  endtask

  task automatic pulsar_seq(input logic [3:0] ks[$]);
    foreach (ks[i]) pulsar(ks[i]);
  endtask

  initial begin
    @(negedge clk);
    chequear("rst_display", display, 16'h0000);
    chequear("rst_neg", display_neg, 1'b0);
    chequear("rst_error", error, 1'b0);
    chequear("rst_ocupado", ocupado, 1'b0);
    chequear("rst_alu_a", alu_a, 16'h0000);
    chequear("rst_alu_b", alu_b, 16'h0000);
    chequear("rst_alu_op", alu_op, 2'b00);
    rst_n = 1'b1;
    ciclos(1);

    // 1: 12 + 34 = 46, latency and busy window
    pulsar_seq('{4'd1, 4'd2});
    chequear("t1_dispA", display, 16'h0012);
    pulsar(4'd10);
    pulsar_seq('{4'd3, 4'd4});
    chequear("t1_dispB", display, 16'h0034);
    chequear("t1_alu_a", alu_a, 16'h0012);
    chequear("t1_alu_b", alu_b, 16'h0034);
    chequear("t1_op", alu_op, 2'b00);
    alu_res = 16'h0046;
    pulsar(4'd14);
    chequear("t1_busy1", ocupado, 1'b1);
    chequear("t1_hold1", display, 16'h0034);
    ciclos(1);
    chequear("t1_busy2", ocupado, 1'b1);
    chequear("t1_hold2", display, 16'h0034);
    ciclos(1);
    chequear("t1_busy_off", ocupado, 1'b0);
    chequear("t1_res", display, 16'h0046);
    chequear("t1_neg", display_neg, 1'b0);

    // 2: negative subtraction, op key then ignored
    pulsar(4'd15);
    pulsar_seq('{4'd5, 4'd11, 4'd8});
    chequear("t2_op", alu_op, 2'b01);
    alu_res = 16'h0003;
    alu_neg = 1'b1;
    pulsar(4'd14);
    ciclos(2);
    chequear("t2_res", display, 16'h0003);
    chequear("t2_neg", display_neg, 1'b1);
    pulsar(4'd10);
    ciclos(1);
    chequear("t2_ign_disp", display, 16'h0003);
    chequear("t2_ign_neg", display_neg, 1'b1);
    alu_neg = 1'b0;

    // 3: fifth digit dropped, overflow to ERROR
    pulsar(4'd15);
    pulsar_seq('{4'd9, 4'd9, 4'd9, 4'd9, 4'd9});
    chequear("t3_full", display, 16'h9999);
    chequear("t3_alu_a", alu_a, 16'h9999);
    pulsar_seq('{4'd12, 4'd2});
    chequear("t3_op", alu_op, 2'b10);
    alu_err = 1'b1;
    pulsar(4'd14);
    ciclos(2);
    chequear("t3_disp_err", display, 16'hFFFF);
    chequear("t3_err", error, 1'b1);
    pulsar(4'd10);
    pulsar(4'd14);
    chequear("t3_stuck", display, 16'hFFFF);
    pulsar(4'd15);
    chequear("t3_clr_disp", display, 16'h0000);
    chequear("t3_clr_err", error, 1'b0);
    chequear("t3_clr_op", alu_op, 2'b00);

    // 4: divide by zero, digits ignored in ERROR
    pulsar_seq('{4'd7, 4'd13, 4'd0});
    chequear("t4_op", alu_op, 2'b11);
    pulsar(4'd14);
    ciclos(2);
    chequear("t4_err", error, 1'b1);
    pulsar(4'd5);
    chequear("t4_dig_ign", display, 16'hFFFF);
    chequear("t4_dig_err", error, 1'b1);
    alu_err = 1'b0;
    pulsar(4'd15);
    chequear("t4_clr_err", error, 1'b0);
    pulsar(4'd6);
    chequear("t4_ingA", display, 16'h0006);
    pulsar(4'd15);

    // 5: chaining, then reset mid-calculation
    pulsar_seq('{4'd2, 4'd10, 4'd3});
    alu_res = 16'h0005;
    pulsar(4'd14);
    ciclos(2);
    chequear("t5_res1", display, 16'h0005);
    pulsar(4'd12);
    chequear("t5_chain_a", alu_a, 16'h0005);
    chequear("t5_chain_op", alu_op, 2'b10);
    chequear("t5_chain_disp", display, 16'h0000);
    pulsar(4'd4);
    alu_res = 16'h0020;
    pulsar(4'd14);
    ciclos(2);
    chequear("t5_res2", display, 16'h0020);
    pulsar(4'd7);
    chequear("t5_newA", display, 16'h0007);
    chequear("t5_newB", alu_b, 16'h0000);
    pulsar_seq('{4'd10, 4'd1});
    pulsar(4'd14);
    chequear("t5_busy", ocupado, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chequear("t5_rst_disp", display, 16'h0000);
    chequear("t5_rst_busy", ocupado, 1'b0);
    chequear("t5_rst_a", alu_a, 16'h0000);
    chequear("t5_rst_b", alu_b, 16'h0000);
    ciclos(1);
    rst_n = 1'b1;
    ciclos(2);
    chequear("t5_no_capture", display, 16'h0000);
    pulsar(4'd3);
    chequear("t5_ingA_after", display, 16'h0003);
    pulsar(4'd15);

    // 6: '=' on a result
    pulsar_seq('{4'd2, 4'd10, 4'd3});
    alu_res = 16'h0005;
    pulsar(4'd14);
    ciclos(2);
    chequear("t6_first", display, 16'h0005);
    alu_res = 16'h0008;
    pulsar(4'd14);
    ciclos(2);
`ifdef CALC_ACUM_EN
    chequear("t6_acum", display, 16'h0008);
    chequear("t6_acum_a", alu_a, 16'h0005);
`else
    chequear("t6_no_acum", display, 16'h0005);
    chequear("t6_no_busy", ocupado, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_ok, n_tot);
    $finish;
  end

endmodule
